// File: rtl/uart_pixel_loader_if.sv
// UART-side Avalon-MM polling bus plus the pixel write-strobe outputs of uart_pixel_loader.
// The master modport is the loader; the slave modport is the UART core / downstream sink.
interface uart_pixel_loader_if;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    logic [7:0]  o_pixel_value;
    logic [19:0] o_addr_store;
    logic        o_pixel_valid;
    logic [1:0]  o_frame_idx;
    logic        o_frame_done;
    logic        o_store_finish;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest,
        output o_pixel_value,
        output o_addr_store,
        output o_pixel_valid,
        output o_frame_idx,
        output o_frame_done,
        output o_store_finish
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest,
        input  o_pixel_value,
        input  o_addr_store,
        input  o_pixel_valid,
        input  o_frame_idx,
        input  o_frame_done,
        input  o_store_finish
    );
endinterface

// File: rtl/uart_pixel_loader.sv
// Polls the UART status register, reads each received byte and emits it as an SRAM write strobe.
// Strobe one cycle after the data-read accept; waitrequest stalls the held read indefinitely.
module uart_pixel_loader #(
    parameter int NUM_PIXELS   = 307200,
    parameter int NUM_FRAMES   = 3,
    parameter int FRAME_STRIDE = 307200,
    parameter int STATUS_ADDR  = 8,
    parameter int RX_ADDR      = 0,
    parameter int RX_OK_BIT    = 7
) (
    input  logic                avm_clk,
    input  logic                avm_rst,
    uart_pixel_loader_if.master bus
);
    localparam int CNT_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

    localparam logic [2:0] S_QUERY      = 3'd0;
    localparam logic [2:0] S_QUERY_IDLE = 3'd1;
    localparam logic [2:0] S_READ       = 3'd2;
    localparam logic [2:0] S_WRITE      = 3'd3;
    localparam logic [2:0] S_DONE       = 3'd4;

    localparam logic [CNT_W-1:0] LAST_PIX   = CNT_W'(NUM_PIXELS - 1);
    localparam logic [1:0]       LAST_FRAME = 2'(NUM_FRAMES - 1);
    localparam logic [19:0]      STRIDE     = 20'(FRAME_STRIDE);
    localparam logic [4:0]       STATUS_A   = 5'(STATUS_ADDR);
    localparam logic [4:0]       RX_A       = 5'(RX_ADDR);

    logic [2:0]       state_q,      state_d;
    logic             read_q,       read_d;
    logic [4:0]       address_q,    address_d;
    logic [CNT_W-1:0] pix_cnt_q,    pix_cnt_d;
    logic [1:0]       frame_q,      frame_d;
    logic [7:0]       value_q,      value_d;
    logic [19:0]      addr_store_q, addr_store_d;
    logic             valid_q,      valid_d;
    logic             done_q,       done_d;
    logic             finish_q,     finish_d;

    logic        accept;
    logic        last_pix;
    logic        last_frame;
    logic [19:0] store_addr;

    assign accept     = read_q & ~bus.avm_waitrequest;
    assign last_pix   = (pix_cnt_q == LAST_PIX);
    assign last_frame = (frame_q == LAST_FRAME);
    // No wrap possible: NUM_FRAMES*FRAME_STRIDE fits in the 20-bit SRAM space.
    assign store_addr = (20'(frame_q) * STRIDE) + 20'(pix_cnt_q);

    always_comb begin
        state_d      = state_q;
        read_d       = read_q;
        address_d    = address_q;
        pix_cnt_d    = pix_cnt_q;
        frame_d      = frame_q;
        value_d      = value_q;
        addr_store_d = addr_store_q;
        valid_d      = 1'b0;
        done_d       = 1'b0;
        finish_d     = finish_q;

        case (state_q)
            S_QUERY: begin
                if (!read_q) begin
                    read_d    = 1'b1;
                    address_d = STATUS_A;
                end else if (accept) begin
                    read_d  = 1'b0;
                    state_d = bus.avm_readdata[RX_OK_BIT] ? S_READ : S_QUERY_IDLE;
                end
            end
            S_QUERY_IDLE: begin
                // Read stays low for exactly this cycle; the next status read is issued here.
                read_d    = 1'b1;
                address_d = STATUS_A;
                state_d   = S_QUERY;
            end
            S_READ: begin
                if (!read_q) begin
                    read_d    = 1'b1;
                    address_d = RX_A;
                end else if (accept) begin
                    read_d       = 1'b0;
                    value_d      = bus.avm_readdata[7:0];
                    addr_store_d = store_addr;
                    valid_d      = 1'b1;
                    done_d       = last_pix;
                    state_d      = S_WRITE;
                end
            end
            S_WRITE: begin
                if (last_pix && last_frame) begin
                    finish_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    if (last_pix) begin
                        pix_cnt_d = '0;
                        frame_d   = frame_q + 2'd1;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                    read_d    = 1'b1;
                    address_d = STATUS_A;
                    state_d   = S_QUERY;
                end
            end
            S_DONE: begin
                read_d = 1'b0;
            end
            default: begin
                read_d  = 1'b0;
                state_d = S_QUERY;
            end
        endcase
    end

    always_ff @(posedge avm_clk or negedge avm_rst) begin
        if (!avm_rst) begin
            state_q      <= S_QUERY;
            read_q       <= 1'b0;
            address_q    <= STATUS_A;
            pix_cnt_q    <= '0;
            frame_q      <= 2'd0;
            value_q      <= 8'd0;
            addr_store_q <= 20'd0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            finish_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            read_q       <= read_d;
            address_q    <= address_d;
            pix_cnt_q    <= pix_cnt_d;
            frame_q      <= frame_d;
            value_q      <= value_d;
            addr_store_q <= addr_store_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
            finish_q     <= finish_d;
        end
    end

    assign bus.avm_read       = read_q;
    assign bus.avm_address    = address_q;
    assign bus.o_pixel_value  = value_q;
    assign bus.o_addr_store   = addr_store_q;
    assign bus.o_pixel_valid  = valid_q;
    assign bus.o_frame_idx    = frame_q;
    assign bus.o_frame_done   = done_q;
    assign bus.o_store_finish = finish_q;
endmodule

// File: tb/tb_uart_pixel_loader.sv
// Bench for uart_pixel_loader with a small geometry (4 pixels x 2 frames, stride 16) and a
// behavioural UART responder; expected addresses come from pixel index arithmetic.
module tb_uart_pixel_loader;
    localparam int NP = 4;
    localparam int NF = 2;
    localparam int ST = 16;

    logic avm_clk = 1'b0;
    logic avm_rst = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   strobe_cnt = 0;

    uart_pixel_loader_if bus ();

    uart_pixel_loader #(
        .NUM_PIXELS   (NP),
        .NUM_FRAMES   (NF),
        .FRAME_STRIDE (ST),
        .STATUS_ADDR  (8),
        .RX_ADDR      (0),
        .RX_OK_BIT    (7)
    ) dut (
        .avm_clk (avm_clk),
        .avm_rst (avm_rst),
        .bus     (bus)
    );

    always #5 avm_clk = ~avm_clk;

    always @(posedge avm_clk) begin
        if (bus.o_pixel_valid === 1'b1) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Answers one Avalon read: waits for it, stalls 'stall' cycles, then accepts with 'data'.
    // Returns at the falling edge following the accepting rising edge.
    task automatic serve(input string tag, input logic [4:0] exp_addr,
                         input logic [31:0] data, input int stall);
        int n = 0;
        logic [4:0] held_addr;
        while (bus.avm_read !== 1'b1 && n < 50) begin
            @(negedge avm_clk);
            n++;
        end
        if (n >= 50) check({tag, "_read_timeout"}, 32'd0, 32'd1);
        check({tag, "_addr"}, 32'(bus.avm_address), 32'(exp_addr));
        held_addr = bus.avm_address;
        for (int i = 0; i < stall; i++) begin
            @(negedge avm_clk);
            check({tag, "_stall_read"}, 32'(bus.avm_read), 32'd1);
            check({tag, "_stall_addr"}, 32'(bus.avm_address), 32'(held_addr));
            check({tag, "_stall_novalid"}, 32'(bus.o_pixel_valid), 32'd0);
        end
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = data;
        @(negedge avm_clk);
        bus.avm_waitrequest = 1'b1;
        bus.avm_readdata    = $urandom;
        check({tag, "_read_drop"}, 32'(bus.avm_read), 32'd0);
    endtask

    initial begin
        logic [7:0]  pix;
        logic [31:0] status_no;
        logic [31:0] status_ok;
        int          polls;
        int          n;
        int          exp_frame_after;

        bus.avm_waitrequest = 1'b1;
        bus.avm_readdata    = $urandom;

        repeat (2) @(negedge avm_clk);
        check("rst_read",   32'(bus.avm_read), 32'd0);
        check("rst_addr",   32'(bus.avm_address), 32'd8);
        check("rst_value",  32'(bus.o_pixel_value), 32'd0);
        check("rst_store",  32'(bus.o_addr_store), 32'd0);
        check("rst_valid",  32'(bus.o_pixel_valid), 32'd0);
        check("rst_frame",  32'(bus.o_frame_idx), 32'd0);
        check("rst_done",   32'(bus.o_frame_done), 32'd0);
        check("rst_finish", 32'(bus.o_store_finish), 32'd0);
        avm_rst = 1'b1;

        // Get into S_READ with the data read stalled, then reset between clock edges.
        serve("pre_status", 5'd8, 32'h0000_0080, 0);
        n = 0;
        while (bus.avm_read !== 1'b1 && n < 50) begin
            @(negedge avm_clk);
            n++;
        end
        if (n >= 50) check("pre_rx_timeout", 32'd0, 32'd1);
        check("pre_rx_addr", 32'(bus.avm_address), 32'd0);
        @(negedge avm_clk);
        #2 avm_rst = 1'b0;
        #1;
        check("arst_read",   32'(bus.avm_read), 32'd0);
        check("arst_addr",   32'(bus.avm_address), 32'd8);
        check("arst_valid",  32'(bus.o_pixel_valid), 32'd0);
        check("arst_frame",  32'(bus.o_frame_idx), 32'd0);
        check("arst_finish", 32'(bus.o_store_finish), 32'd0);
        @(negedge avm_clk);
        avm_rst = 1'b1;

        for (int k = 0; k < NP * NF; k++) begin
            pix   = (k == 0) ? 8'hA5 : 8'($urandom);
            polls = (k == 0) ? 3 : int'($urandom_range(0, 2));
            for (int p = 0; p < polls; p++) begin
                status_no = $urandom & 32'hFFFF_FF7F;
                serve("poll", 5'd8, status_no, int'($urandom_range(0, 2)));
                check("poll_novalid", 32'(bus.o_pixel_valid), 32'd0);
            end
            status_ok = $urandom | 32'h0000_0080;
            serve("status", 5'd8, status_ok, int'($urandom_range(0, 2)));
            serve("data", 5'd0, {24'($urandom), pix}, (k == 0) ? 5 : int'($urandom_range(0, 3)));

            check("strobe_valid", 32'(bus.o_pixel_valid), 32'd1);
            check("strobe_value", 32'(bus.o_pixel_value), 32'(pix));
            check("strobe_addr",  32'(bus.o_addr_store), 32'((k / NP) * ST + (k % NP)));
            check("strobe_done",  32'(bus.o_frame_done), (k % NP == NP - 1) ? 32'd1 : 32'd0);
            check("strobe_frame", 32'(bus.o_frame_idx), 32'(k / NP));
            check("strobe_finish", 32'(bus.o_store_finish), 32'd0);

            @(negedge avm_clk);
            exp_frame_after = ((k + 1) / NP < NF) ? (k + 1) / NP : NF - 1;
            check("post_valid",  32'(bus.o_pixel_valid), 32'd0);
            check("post_done",   32'(bus.o_frame_done), 32'd0);
            check("post_hold",   32'(bus.o_pixel_value), 32'(pix));
            check("post_frame",  32'(bus.o_frame_idx), 32'(exp_frame_after));
            check("post_finish", 32'(bus.o_store_finish), (k == NP * NF - 1) ? 32'd1 : 32'd0);
        end

        // Terminal state: an always-ready UART with data available must be ignored.
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = 32'h0000_0080;
        for (int i = 0; i < 20; i++) begin
            @(negedge avm_clk);
            check("done_noread",  32'(bus.avm_read), 32'd0);
            check("done_finish",  32'(bus.o_store_finish), 32'd1);
            check("done_novalid", 32'(bus.o_pixel_valid), 32'd0);
        end
        check("strobe_count", 32'(strobe_cnt), 32'(NP * NF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
